mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the riscv core's instruction-fetch port and data port.

---
 rtl/dragon_mem_pkg.sv | 33 +++
 rtl/mem_arb_prio.sv | 52 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragon_mem_pkg.sv
// Shared types and helpers for the unified-memory arbiter between fetch and data ports.
package dragon_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_I = 3'd1,
        WAIT_D = 3'd2,
        ERR_I  = 3'd3,
        ERR_D  = 3'd4
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam int unsigned ADDR_CHECK_W = 64;

    // True when any byte-address bit above the word-addressable window is set.
    function automatic logic addr_out_of_range(input logic [ADDR_CHECK_W-1:0] addr,
                                               input int unsigned xlen,
                                               input int unsigned addr_w);
        logic oor;
        oor = 1'b0;
        for (int unsigned b = 0; b < ADDR_CHECK_W; b++) begin
            if ((b >= addr_w + 2) && (b < xlen) && addr[b]) begin
                oor = 1'b1;
            end
        end
        return oor;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Picks the winner in a grant slot: data first, fetch once it has watched STARVE_LIMIT data grants.
module mem_arb_prio
    import dragon_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    slot_i,
    input  logic    i_req_i,
    input  logic    d_req_i,
    output logic    gnt_valid_o,
    output req_id_t winner_o
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                starved;

    assign starved = (streak_q == STREAK_W'(STARVE_LIMIT));

    always_comb begin
        gnt_valid_o = slot_i && (i_req_i || d_req_i);
        winner_o    = REQ_I;
        streak_d    = streak_q;

        if (d_req_i && !(i_req_i && starved)) begin
            winner_o = REQ_D;
        end

        // Streak only counts data grants that overtook a waiting fetch.
        if (!i_req_i) begin
            streak_d = '0;
        end else if (gnt_valid_o) begin
            if (winner_o == REQ_I) begin
                streak_d = '0;
            end else if (!starved) begin
                streak_d = streak_q + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and data access,
// answering out-of-range addresses locally with an error response.
module mem_arbiter
    import dragon_mem_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MEMORY_CAPACITY = 256,
    parameter int unsigned STARVE_LIMIT    = 4,
    localparam int unsigned ADDR_W         = $clog2(MEMORY_CAPACITY),
    localparam int unsigned BE_W           = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,

    output logic              m_req,
    output logic              m_we,
    output logic [BE_W-1:0]   m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [XLEN-1:0]   m_wdata,
    input  logic [XLEN-1:0]   m_rdata,
    input  logic              m_rvalid
);

    arb_state_t      state_q, state_d;
    logic            d_we_q, d_we_d;
    logic            slot;
    logic            gnt_valid;
    logic            sel_oor;
    req_id_t         winner;
    logic [XLEN-1:0] sel_addr;

    // A new command may issue when idle, while an error is answered, or as memory responds.
    assign slot = reset && ((state_q == IDLE) || (state_q == ERR_I) || (state_q == ERR_D) ||
                            (((state_q == WAIT_I) || (state_q == WAIT_D)) && m_rvalid));

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk         (clk),
        .reset       (reset),
        .slot_i      (slot),
        .i_req_i     (i_req),
        .d_req_i     (d_req),
        .gnt_valid_o (gnt_valid),
        .winner_o    (winner)
    );

    assign sel_addr = (winner == REQ_D) ? d_addr : i_addr;
    assign sel_oor  = addr_out_of_range(64'(sel_addr), XLEN, ADDR_W);

    always_comb begin
        state_d  = state_q;
        d_we_d   = d_we_q;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_be     = '0;
        m_addr   = '0;
        m_wdata  = '0;

        // Response routing for the transaction finishing this cycle.
        case (state_q)
            WAIT_I: begin
                if (m_rvalid) begin
                    i_rvalid = 1'b1;
                    i_rdata  = m_rdata;
                end
            end
            WAIT_D: begin
                if (m_rvalid) begin
                    d_rvalid = 1'b1;
                    d_rdata  = d_we_q ? '0 : m_rdata;
                end
            end
            ERR_I: begin
                i_rvalid = 1'b1;
                i_err    = 1'b1;
            end
            ERR_D: begin
                d_rvalid = 1'b1;
                d_err    = 1'b1;
            end
            default: ;
        endcase

        if (slot) begin
            state_d = IDLE;
            if (gnt_valid) begin
                if (winner == REQ_D) begin
                    d_gnt   = 1'b1;
                    d_we_d  = d_we;
                    state_d = sel_oor ? ERR_D : WAIT_D;
                    m_we    = d_we && !sel_oor;
                    m_be    = sel_oor ? '0 : d_be;
                    m_wdata = sel_oor ? '0 : d_wdata;
                end else begin
                    i_gnt   = 1'b1;
                    state_d = sel_oor ? ERR_I : WAIT_I;
                    m_be    = sel_oor ? '0 : '1;
                end
                m_req = !sel_oor;
                if (!sel_oor) begin
                    m_addr = sel_addr[ADDR_W+1:2];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            d_we_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_we_q  <= d_we_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CAP   = 256;
    localparam int unsigned LIMIT = 4;
    localparam int          NV    = 10;
    localparam logic        H     = 1'b1;
    localparam logic        L     = 1'b0;
    localparam logic [31:0] DB    = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_rvalid;
    logic [3:0]  m_be;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .XLEN            (XLEN),
        .MEMORY_CAPACITY (CAP),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid)
    );

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_m_req;
        logic        e_m_we;
        logic [3:0]  e_m_be;
        logic [7:0]  e_m_addr;
        logic [31:0] e_m_wdata;
        logic        e_i_rv;
        logic        e_d_rv;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    vec_t        vec [NV];
    logic [31:0] marr [CAP];
    logic [31:0] refmem [CAP];
    rsp_t        iq [$];
    rsp_t        dq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_rvalid = 1'b0; m_rdata = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom | (32'h400 << $urandom_range(0, 21));
        end else begin
            a = {22'b0, 8'($urandom), 2'($urandom)};
        end
        return a;
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return (a >> 10) == 32'h0;
    endfunction

    initial begin
        rsp_t        r;
        logic        i_pend, d_pend;
        int          fetch_waits, mem_cd;
        logic [31:0] mem_data;
        logic [1:0]  order_exp;

        vec[0] = '{H, 32'h10, L, L, 4'h0, 32'h0, 32'h0, H, L, H, L, 4'hF, 8'h04, 32'h0, H, L, L, DB};
        vec[1] = '{H, 32'h10, H, L, 4'hF, 32'h20, 32'h0, L, H, H, L, 4'hF, 8'h08, 32'h0, L, H, L, DB};
        vec[2] = '{L, 32'h0, H, L, 4'hF, 32'h400, 32'h0, L, H, L, L, 4'h0, 8'h00, 32'h0, L, H, H, 32'h0};
        vec[3] = '{L, 32'h0, H, H, 4'h3, 32'h8, 32'h12345678, L, H, H, H, 4'h3, 8'h02, 32'h12345678, L, H, L, 32'h0};
        vec[4] = '{L, 32'h0, L, L, 4'h0, 32'h0, 32'h0, L, L, L, L, 4'h0, 8'h00, 32'h0, L, L, L, 32'h0};
        vec[5] = '{H, 32'h80000000, L, L, 4'h0, 32'h0, 32'h0, H, L, L, L, 4'h0, 8'h00, 32'h0, H, L, H, 32'h0};
        vec[6] = '{H, 32'h3FF, L, L, 4'h0, 32'h0, 32'h0, H, L, H, L, 4'hF, 8'hFF, 32'h0, H, L, L, DB};
        vec[7] = '{H, 32'h10, H, L, 4'hF, 32'h404, 32'h0, L, H, L, L, 4'h0, 8'h00, 32'h0, L, H, H, 32'h0};
        vec[8] = '{L, 32'h0, H, L, 4'h5, 32'h3, 32'h0, L, H, H, L, 4'h5, 8'h00, 32'h0, L, H, L, DB};
        vec[9] = '{L, 32'h0, H, H, 4'hF, 32'h3FC, 32'hA5A5A5A5, L, H, H, H, 4'hF, 8'hFF, 32'hA5A5A5A5, L, H, L, 32'h0};

        // Reset: requests present but nothing may be granted or issued.
        idle_inputs();
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h20;
        @(negedge clk);
        chk("rst_i_gnt", 32'(i_gnt), 32'h0);
        chk("rst_d_gnt", 32'(d_gnt), 32'h0);
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_we", 32'(m_we), 32'h0);
        chk("rst_rvalid", 32'({i_rvalid, d_rvalid, i_err, d_err}), 32'h0);
        tick();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();

        // Directed table: one transaction from IDLE, then one cycle with m_rvalid=1.
        for (int k = 0; k < NV; k++) begin
            i_req = vec[k].i_req; i_addr = vec[k].i_addr;
            d_req = vec[k].d_req; d_we = vec[k].d_we; d_be = vec[k].d_be;
            d_addr = vec[k].d_addr; d_wdata = vec[k].d_wdata;
            m_rvalid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_i_gnt", k), 32'(i_gnt), 32'(vec[k].e_i_gnt));
            chk($sformatf("v%0d_d_gnt", k), 32'(d_gnt), 32'(vec[k].e_d_gnt));
            chk($sformatf("v%0d_m_req", k), 32'(m_req), 32'(vec[k].e_m_req));
            if (vec[k].e_m_req) begin
                chk($sformatf("v%0d_m_we", k), 32'(m_we), 32'(vec[k].e_m_we));
                chk($sformatf("v%0d_m_be", k), 32'(m_be), 32'(vec[k].e_m_be));
                chk($sformatf("v%0d_m_addr", k), 32'(m_addr), 32'(vec[k].e_m_addr));
                if (vec[k].e_m_we) chk($sformatf("v%0d_m_wdata", k), m_wdata, vec[k].e_m_wdata);
            end
            tick();
            idle_inputs();
            m_rvalid = 1'b1; m_rdata = DB;
            @(negedge clk);
            chk($sformatf("v%0d_i_rvalid", k), 32'(i_rvalid), 32'(vec[k].e_i_rv));
            chk($sformatf("v%0d_d_rvalid", k), 32'(d_rvalid), 32'(vec[k].e_d_rv));
            chk($sformatf("v%0d_i_rdata", k), i_rdata, vec[k].e_i_rv ? vec[k].e_rdata : 32'h0);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, vec[k].e_d_rv ? vec[k].e_rdata : 32'h0);
            chk($sformatf("v%0d_i_err", k), 32'(i_err), 32'(vec[k].e_i_rv & vec[k].e_err));
            chk($sformatf("v%0d_d_err", k), 32'(d_err), 32'(vec[k].e_d_rv & vec[k].e_err));
            tick();
            m_rvalid = 1'b0;
            tick();
        end

        // Both in IDLE: data first, fetch issues back-to-back on data's response.
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_addr = 32'h48; d_we = 1'b0; d_be = 4'hF;
        @(negedge clk);
        chk("b2b_d_first", 32'({i_gnt, d_gnt}), 32'h1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("b2b_no_gnt_in_wait", 32'({i_gnt, d_gnt}), 32'h0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h1111;
        @(negedge clk);
        chk("b2b_d_rvalid", 32'(d_rvalid), 32'h1);
        chk("b2b_d_rdata", d_rdata, 32'h1111);
        chk("b2b_i_gnt", 32'(i_gnt), 32'h1);
        chk("b2b_i_m_addr", 32'(m_addr), 32'h11);
        tick();
        i_req = 1'b0; m_rdata = 32'h2222;
        @(negedge clk);
        chk("b2b_i_rvalid", 32'(i_rvalid), 32'h1);
        chk("b2b_i_rdata", i_rdata, 32'h2222);
        chk("b2b_d_quiet", 32'(d_rvalid), 32'h0);
        tick();
        idle_inputs();
        tick();

        // Starvation guard with 1-cycle memory: D,D,D,D,I repeating.
        i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_addr = 32'h8; d_we = 1'b0; d_be = 4'hF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            order_exp = ((c % 5) == 4) ? 2'b10 : 2'b01;
            chk($sformatf("starve_order_%0d", c), 32'({i_gnt, d_gnt}), 32'(order_exp));
            tick();
            m_rvalid = 1'b1; m_rdata = 32'(c);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        idle_inputs();
        tick();

        // Reset while WAIT_D: the late response must be dropped.
        d_req = 1'b1; d_addr = 32'h20; d_we = 1'b0; d_be = 4'hF;
        @(negedge clk);
        chk("rstmid_d_gnt", 32'(d_gnt), 32'h1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_m_req", 32'(m_req), 32'h0);
        tick();
        reset = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'h5555;
        @(negedge clk);
        chk("rstmid_late_rvalid", 32'({d_rvalid, i_rvalid}), 32'h0);
        tick();
        m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h30;
        @(negedge clk);
        chk("rstmid_i_gnt", 32'(i_gnt), 32'h1);
        chk("rstmid_i_m_req", 32'(m_req), 32'h1);
        chk("rstmid_i_m_addr", 32'(m_addr), 32'h0C);
        tick();
        i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h7777;
        @(negedge clk);
        chk("rstmid_i_rdata", i_rdata, 32'h7777);
        tick();
        idle_inputs();
        tick();

        // Randomized traffic against a request-level reference memory and fairness rule.
        for (int i = 0; i < int'(CAP); i++) begin
            marr[i]   = $urandom;
            refmem[i] = marr[i];
        end
        i_pend = 1'b0; d_pend = 1'b0; fetch_waits = 0; mem_cd = 0; mem_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (mem_cd > 0) begin
                mem_cd--;
                m_rvalid = (mem_cd == 0);
                m_rdata  = mem_data;
            end else begin
                m_rvalid = 1'b0;
                m_rdata  = $urandom;
            end
            if (!i_pend && cyc < 2800 && $urandom_range(0, 3) != 0) begin
                i_pend = 1'b1; i_addr = rand_addr();
            end
            if (!d_pend && cyc < 2800 && $urandom_range(0, 2) != 0) begin
                d_pend = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom);
                d_be = 4'($urandom); d_wdata = $urandom;
            end
            i_req = i_pend; d_req = d_pend;
            @(negedge clk);

            if (i_rvalid) begin
                if (iq.size() == 0) begin
                    chk("rnd_i_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    r = iq.pop_front();
                    chk("rnd_i_rdata", i_rdata, r.data);
                    chk("rnd_i_err", 32'(i_err), 32'(r.err));
                end
            end else begin
                chk("rnd_i_idle_bus", {i_rdata[31:1], i_rdata[0] | i_err}, 32'h0);
            end
            if (d_rvalid) begin
                if (dq.size() == 0) begin
                    chk("rnd_d_unexpected_rvalid", 32'h1, 32'h0);
                end else begin
                    r = dq.pop_front();
                    chk("rnd_d_rdata", d_rdata, r.data);
                    chk("rnd_d_err", 32'(d_err), 32'(r.err));
                end
            end else begin
                chk("rnd_d_idle_bus", {d_rdata[31:1], d_rdata[0] | d_err}, 32'h0);
            end

            if (i_gnt || d_gnt) begin
                chk("rnd_gnt_has_req", 32'((i_gnt && !i_pend) || (d_gnt && !d_pend) || (i_gnt && d_gnt)), 32'h0);
                if (i_pend && d_pend) begin
                    chk("rnd_winner", 32'({i_gnt, d_gnt}), (fetch_waits == int'(LIMIT)) ? 32'h2 : 32'h1);
                end
                if (d_gnt) begin
                    if (i_pend) fetch_waits++;
                    chk("rnd_d_m_req", 32'(m_req), 32'(in_range(d_addr)));
                    if (!in_range(d_addr)) begin
                        r.err = 1'b1; r.data = '0;
                    end else begin
                        chk("rnd_d_m_addr", 32'(m_addr), 32'(d_addr[9:2]));
                        r.err = 1'b0;
                        if (d_we) begin
                            refmem[d_addr[9:2]] = merge(refmem[d_addr[9:2]], d_wdata, d_be);
                            r.data = '0;
                        end else begin
                            r.data = refmem[d_addr[9:2]];
                        end
                    end
                    dq.push_back(r);
                    d_pend = 1'b0;
                end else begin
                    fetch_waits = 0;
                    chk("rnd_i_m_req", 32'(m_req), 32'(in_range(i_addr)));
                    if (in_range(i_addr)) chk("rnd_i_m_addr", 32'(m_addr), 32'(i_addr[9:2]));
                    r.err  = !in_range(i_addr);
                    r.data = in_range(i_addr) ? refmem[i_addr[9:2]] : 32'h0;
                    iq.push_back(r);
                    i_pend = 1'b0;
                end
            end else begin
                chk("rnd_m_req_without_gnt", 32'(m_req), 32'h0);
            end
            if (!i_pend) fetch_waits = 0;

            if (m_req) begin
                if (m_we) marr[m_addr] = merge(marr[m_addr], m_wdata, m_be);
                mem_data = m_we ? $urandom : marr[m_addr];
                mem_cd   = $urandom_range(1, 3);
            end
            tick();
        end
        chk("drain_i_queue", 32'(iq.size()), 32'h0);
        chk("drain_d_queue", 32'(dq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
